// File: rtl/rv0_fpu_ctrl_pkg.sv
// rv0_fpu_ctrl_pkg
//   Shared definitions for the FP sequencer: RV32F opcode/funct encodings,
//   rounding modes, FP CSR addresses, fflags bit positions, the sequencer
//   state type and the issue-time legality check.
package rv0_fpu_ctrl_pkg;

  localparam logic [6:0] OP_FP           = 7'b1010011;

  localparam logic [6:0] FUNCT7_FADD_S      = 7'b0000000;
  localparam logic [6:0] FUNCT7_FSUB_S      = 7'b0000100;
  localparam logic [6:0] FUNCT7_FMUL_S      = 7'b0001000;
  localparam logic [6:0] FUNCT7_FMIN_FMAX_S = 7'b0010100;

  localparam logic [2:0] RNE = 3'd0;
  localparam logic [2:0] RTZ = 3'd1;
  localparam logic [2:0] RDN = 3'd2;
  localparam logic [2:0] RUP = 3'd3;
  localparam logic [2:0] RMM = 3'd4;
  localparam logic [2:0] DYN = 3'd7;

  localparam logic [2:0] FMIN = 3'b000;
  localparam logic [2:0] FMAX = 3'b001;

  localparam logic [11:0] CSR_FFLAGS = 12'h001;
  localparam logic [11:0] CSR_FRM    = 12'h002;
  localparam logic [11:0] CSR_FCSR   = 12'h003;

  localparam int unsigned FFLAG_NV = 4;
  localparam int unsigned FFLAG_DZ = 3;
  localparam int unsigned FFLAG_OF = 2;
  localparam int unsigned FFLAG_UF = 1;
  localparam int unsigned FFLAG_NX = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } fpu_state_e;

  // Rounding only matters for the arithmetic ops; min/max reuse funct3 as
  // the min/max select, so the rm check must not be applied to them.
  function automatic logic fpu_insn_legal(input logic [31:0] insn,
                                          input logic [2:0]  frm);
    logic [2:0] f3;
    logic [2:0] rm;
    f3 = insn[14:12];
    rm = (f3 == DYN) ? frm : f3;
    if (insn[6:0] != OP_FP) return 1'b0;
    case (insn[31:25])
      FUNCT7_FADD_S,
      FUNCT7_FSUB_S,
      FUNCT7_FMUL_S:      return rm inside {RNE, RTZ, RDN, RUP, RMM};
      FUNCT7_FMIN_FMAX_S: return f3 inside {FMIN, FMAX};
      default:            return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rv0_fpu_ctrl_if.sv
// rv0_fpu_ctrl_if
//   Issue/response handshake between the core (master) and the FP
//   sequencer (slave).
//   master drives: fpu_req_valid, fpu_req_insn, fpu_req_rdata1/2,
//                  fpu_flush, fpu_rsp_ready
//   slave drives:  fpu_req_ready, fpu_rsp_valid, fpu_rsp_wdata,
//                  fpu_rsp_rd, fpu_rsp_illegal
interface rv0_fpu_ctrl_if #(
  parameter int unsigned FLEN = 32
);

  logic            fpu_req_valid;
  logic            fpu_req_ready;
  logic [31:0]     fpu_req_insn;
  logic [FLEN-1:0] fpu_req_rdata1;
  logic [FLEN-1:0] fpu_req_rdata2;
  logic            fpu_flush;
  logic            fpu_rsp_valid;
  logic            fpu_rsp_ready;
  logic [FLEN-1:0] fpu_rsp_wdata;
  logic [4:0]      fpu_rsp_rd;
  logic            fpu_rsp_illegal;

  modport master (
    output fpu_req_valid, fpu_req_insn, fpu_req_rdata1, fpu_req_rdata2,
           fpu_flush, fpu_rsp_ready,
    input  fpu_req_ready, fpu_rsp_valid, fpu_rsp_wdata, fpu_rsp_rd,
           fpu_rsp_illegal
  );

  modport slave (
    input  fpu_req_valid, fpu_req_insn, fpu_req_rdata1, fpu_req_rdata2,
           fpu_flush, fpu_rsp_ready,
    output fpu_req_ready, fpu_rsp_valid, fpu_rsp_wdata, fpu_rsp_rd,
           fpu_rsp_illegal
  );

endinterface

// File: rtl/rv0_fpu_ctrl_csr.sv
// rv0_fpu_ctrl_csr
//   frm/fflags architectural registers, CSR read mux and flag accrual.
//   clk_i, rst_i        clock, async active-high reset
//   csr_we_i/addr/wdata CSR write port
//   csr_rdata_o         combinational read of csr_addr_i
//   accrue_en_i         OR accrue_flags_i into fflags this cycle
//   frm_o, fflags_o     current register values
module rv0_fpu_ctrl_csr
  import rv0_fpu_ctrl_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        csr_we_i,
  input  logic [11:0] csr_addr_i,
  input  logic [31:0] csr_wdata_i,
  output logic [31:0] csr_rdata_o,
  input  logic        accrue_en_i,
  input  logic [4:0]  accrue_flags_i,
  output logic [2:0]  frm_o,
  output logic [4:0]  fflags_o
);

  logic [2:0] frm_q;
  logic [4:0] fflags_q;
  logic [2:0] frm_d;
  logic [4:0] fflags_d;
  logic       unused_wdata_hi;

  assign unused_wdata_hi = ^csr_wdata_i[31:8];

  // A software write and a retiring op can land in the same cycle; the
  // written value is the base and the op's flags are still merged in.
  always_comb begin
    frm_d    = frm_q;
    fflags_d = fflags_q;
    if (csr_we_i) begin
      case (csr_addr_i)
        CSR_FFLAGS: fflags_d = csr_wdata_i[4:0];
        CSR_FRM:    frm_d    = csr_wdata_i[2:0];
        CSR_FCSR: begin
          frm_d    = csr_wdata_i[7:5];
          fflags_d = csr_wdata_i[4:0];
        end
        default: ;
      endcase
    end
    if (accrue_en_i) fflags_d = fflags_d | accrue_flags_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      frm_q    <= '0;
      fflags_q <= '0;
    end else begin
      frm_q    <= frm_d;
      fflags_q <= fflags_d;
    end
  end

  always_comb begin
    csr_rdata_o = '0;
    case (csr_addr_i)
      CSR_FFLAGS: csr_rdata_o = {27'b0, fflags_q};
      CSR_FRM:    csr_rdata_o = {29'b0, frm_q};
      CSR_FCSR:   csr_rdata_o = {24'b0, frm_q, fflags_q};
      default:    csr_rdata_o = '0;
    endcase
  end

  assign frm_o    = frm_q;
  assign fflags_o = fflags_q;

endmodule

// File: rtl/rv0_fpu_ctrl.sv
// rv0_fpu_ctrl
//   Sequencer for the combinational single-precision FP ALU. Accepts one
//   instruction, holds its operands stable for FPU_LAT cycles (multicycle
//   path into the ALU), captures result/flags, returns them over a
//   valid/ready response and accrues flags into fflags on the handshake.
//   clk_i, rst_i      clock, async active-high reset
//   fpu               issue/response handshake (slave side) incl. flush
//   alu_f_*_o/_i      latched operands out to / result and flags in from ALU
//   csr_*             CSR read/write port for fflags/frm/fcsr
//   fcsr_frm_o/fflags_o current architectural frm / fflags
module rv0_fpu_ctrl
  import rv0_fpu_ctrl_pkg::*;
#(
  parameter int unsigned FLEN    = 32,
  parameter int unsigned FPU_LAT = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  rv0_fpu_ctrl_if.slave   fpu,
  output logic [31:0]     alu_f_insn_o,
  output logic [FLEN-1:0] alu_f_rdata1_o,
  output logic [FLEN-1:0] alu_f_rdata2_o,
  output logic [2:0]      alu_f_frm_o,
  input  logic [FLEN-1:0] alu_f_wdata_i,
  input  logic [4:0]      alu_f_fflags_i,
  input  logic            csr_we_i,
  input  logic [11:0]     csr_addr_i,
  input  logic [31:0]     csr_wdata_i,
  output logic [31:0]     csr_rdata_o,
  output logic [2:0]      fcsr_frm_o,
  output logic [4:0]      fcsr_fflags_o
);

  localparam int unsigned CNT_W = (FPU_LAT > 1) ? $clog2(FPU_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(FPU_LAT - 1);

  fpu_state_e      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]     insn_q;
  logic [FLEN-1:0] rs1_q;
  logic [FLEN-1:0] rs2_q;
  logic [2:0]      frm_q;
  logic [FLEN-1:0] rsp_wdata_q;
  logic [4:0]      rsp_flags_q;
  logic            illegal_q;

  logic accept;
  logic insn_legal;
  logic accrue_en;

  assign fpu.fpu_req_ready = (state_q == IDLE) && !fpu.fpu_flush;
  assign accept            = fpu.fpu_req_valid && fpu.fpu_req_ready;
  // Checked against the pre-write frm so a same-cycle FRM write cannot
  // change the rm an already-accepted op resolves to.
  assign insn_legal        = fpu_insn_legal(fpu.fpu_req_insn, fcsr_frm_o);
  assign accrue_en         = (state_q == RESP) && fpu.fpu_rsp_ready && !fpu.fpu_flush;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      insn_q      <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      frm_q       <= '0;
      rsp_wdata_q <= '0;
      rsp_flags_q <= '0;
      illegal_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            insn_q <= fpu.fpu_req_insn;
            rs1_q  <= fpu.fpu_req_rdata1;
            rs2_q  <= fpu.fpu_req_rdata2;
            frm_q  <= fcsr_frm_o;
            if (insn_legal) begin
              state_q   <= EXEC;
              cnt_q     <= CNT_INIT;
              illegal_q <= 1'b0;
            end else begin
              state_q     <= RESP;
              illegal_q   <= 1'b1;
              rsp_wdata_q <= '0;
              rsp_flags_q <= '0;
            end
          end
        end
        EXEC: begin
          if (fpu.fpu_flush) begin
            state_q <= IDLE;
          end else if (cnt_q == '0) begin
            rsp_wdata_q <= alu_f_wdata_i;
            rsp_flags_q <= alu_f_fflags_i;
            state_q     <= RESP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RESP: begin
          if (fpu.fpu_flush || fpu.fpu_rsp_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign alu_f_insn_o   = insn_q;
  assign alu_f_rdata1_o = rs1_q;
  assign alu_f_rdata2_o = rs2_q;
  assign alu_f_frm_o    = frm_q;

  assign fpu.fpu_rsp_valid   = (state_q == RESP);
  assign fpu.fpu_rsp_wdata   = rsp_wdata_q;
  assign fpu.fpu_rsp_rd      = insn_q[11:7];
  assign fpu.fpu_rsp_illegal = illegal_q;

  rv0_fpu_ctrl_csr u_csr (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .csr_we_i       (csr_we_i),
    .csr_addr_i     (csr_addr_i),
    .csr_wdata_i    (csr_wdata_i),
    .csr_rdata_o    (csr_rdata_o),
    .accrue_en_i    (accrue_en),
    .accrue_flags_i (rsp_flags_q),
    .frm_o          (fcsr_frm_o),
    .fflags_o       (fcsr_fflags_o)
  );

endmodule

// File: tb/tb_rv0_fpu_ctrl.sv
// tb_rv0_fpu_ctrl
//   Directed bench for rv0_fpu_ctrl. The FP ALU is stood in for by the bench
//   driving alu_f_wdata_i / alu_f_fflags_i with hand-computed results.
module tb_rv0_fpu_ctrl;

  localparam logic [6:0] T_F7_ADD = 7'b0000000;
  localparam logic [6:0] T_F7_MUL = 7'b0001000;
  localparam logic [6:0] T_F7_MM  = 7'b0010100;
  localparam logic [6:0] T_F7_DIV = 7'b0001100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] alu_f_insn;
  logic [31:0] alu_f_rdata1;
  logic [31:0] alu_f_rdata2;
  logic [2:0]  alu_f_frm;
  logic [31:0] alu_f_wdata = '0;
  logic [4:0]  alu_f_fflags = '0;
  logic        csr_we = 1'b0;
  logic [11:0] csr_addr = '0;
  logic [31:0] csr_wdata = '0;
  logic [31:0] csr_rdata;
  logic [2:0]  fcsr_frm;
  logic [4:0]  fcsr_fflags;

  int checks = 0;
  int errors = 0;

  rv0_fpu_ctrl_if #(.FLEN(32)) fpu_if ();

  rv0_fpu_ctrl #(.FLEN(32), .FPU_LAT(2)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .fpu            (fpu_if),
    .alu_f_insn_o   (alu_f_insn),
    .alu_f_rdata1_o (alu_f_rdata1),
    .alu_f_rdata2_o (alu_f_rdata2),
    .alu_f_frm_o    (alu_f_frm),
    .alu_f_wdata_i  (alu_f_wdata),
    .alu_f_fflags_i (alu_f_fflags),
    .csr_we_i       (csr_we),
    .csr_addr_i     (csr_addr),
    .csr_wdata_i    (csr_wdata),
    .csr_rdata_o    (csr_rdata),
    .fcsr_frm_o     (fcsr_frm),
    .fcsr_fflags_o  (fcsr_fflags)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3,
                                     input logic [4:0] rd);
    return {f7, 5'd2, 5'd1, f3, rd, 7'b1010011};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] insn, input logic [31:0] a, input logic [31:0] b);
    fpu_if.fpu_req_valid  = 1'b1;
    fpu_if.fpu_req_insn   = insn;
    fpu_if.fpu_req_rdata1 = a;
    fpu_if.fpu_req_rdata2 = b;
    step();
    fpu_if.fpu_req_valid  = 1'b0;
  endtask

  // Edges after the accept edge until rsp_valid; bounded.
  task automatic wait_rsp(output int n);
    n = 0;
    while (!fpu_if.fpu_rsp_valid && n < 20) begin
      step();
      n++;
    end
  endtask

  task automatic handshake();
    fpu_if.fpu_rsp_ready = 1'b1;
    step();
    fpu_if.fpu_rsp_ready = 1'b0;
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
    csr_we = 1'b1; csr_addr = a; csr_wdata = d;
    step();
    csr_we = 1'b0;
  endtask

  task automatic csr_read(input logic [11:0] a, output logic [31:0] d);
    csr_addr = a;
    #1;
    d = csr_rdata;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    checks++; if (fpu_if.fpu_req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0h want 1", fpu_if.fpu_req_ready); end
    checks++; if (fpu_if.fpu_rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %0h want 0", fpu_if.fpu_rsp_valid); end
    checks++; if (fpu_if.fpu_rsp_illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal got %0h want 0", fpu_if.fpu_rsp_illegal); end
    checks++; if (alu_f_insn !== 32'h0) begin errors++; $display("FAIL reset_alu_insn got %h want 0", alu_f_insn); end
    checks++; if ({fcsr_frm, fcsr_fflags} !== 8'h00) begin errors++; $display("FAIL reset_fcsr got %h want 00", {fcsr_frm, fcsr_fflags}); end
    csr_read(12'h003, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_csr_rdata got %h want 0", d); end
  endtask

  task automatic test_fadd();
    int n;
    logic [31:0] insn;
    insn = mk(T_F7_ADD, 3'd0, 5'd3);
    alu_f_wdata = 32'h40000000; alu_f_fflags = 5'h00;
    issue(insn, 32'h3F800000, 32'h3F800000);
    checks++; if (alu_f_insn !== insn) begin errors++; $display("FAIL fadd_alu_insn got %h want %h", alu_f_insn, insn); end
    checks++; if (alu_f_rdata1 !== 32'h3F800000 || alu_f_rdata2 !== 32'h3F800000) begin errors++; $display("FAIL fadd_alu_ops got %h %h want 3f800000", alu_f_rdata1, alu_f_rdata2); end
    checks++; if (fpu_if.fpu_req_ready !== 1'b0) begin errors++; $display("FAIL fadd_busy_ready got %0h want 0", fpu_if.fpu_req_ready); end
    wait_rsp(n);
    // rsp_valid in the third cycle after the accept cycle: FPU_LAT edges past the accept edge
    checks++; if (n != 2) begin errors++; $display("FAIL fadd_latency got %0d want 2", n); end
    checks++; if (fpu_if.fpu_rsp_wdata !== 32'h40000000) begin errors++; $display("FAIL fadd_wdata got %h want 40000000", fpu_if.fpu_rsp_wdata); end
    checks++; if (fpu_if.fpu_rsp_rd !== 5'd3 || fpu_if.fpu_rsp_illegal !== 1'b0) begin errors++; $display("FAIL fadd_rd_ill got %0d %0h want 3 0", fpu_if.fpu_rsp_rd, fpu_if.fpu_rsp_illegal); end
    handshake();
    checks++; if (fcsr_fflags !== 5'h00) begin errors++; $display("FAIL fadd_fflags got %h want 00", fcsr_fflags); end
    checks++; if (fpu_if.fpu_rsp_valid !== 1'b0 || fpu_if.fpu_req_ready !== 1'b1) begin errors++; $display("FAIL fadd_idle got v=%0h r=%0h want v=0 r=1", fpu_if.fpu_rsp_valid, fpu_if.fpu_req_ready); end
  endtask

  task automatic test_fmul_hold();
    int n;
    logic [31:0] d;
    alu_f_wdata = 32'h3F800002; alu_f_fflags = 5'h01;
    issue(mk(T_F7_MUL, 3'd0, 5'd7), 32'h3F800001, 32'h3F800001);
    wait_rsp(n);
    checks++; if (n != 2) begin errors++; $display("FAIL fmul_latency got %0d want 2", n); end
    alu_f_wdata = 32'hDEADBEEF; alu_f_fflags = 5'h1F;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (fpu_if.fpu_rsp_valid !== 1'b1 || fpu_if.fpu_rsp_wdata !== 32'h3F800002 || fpu_if.fpu_rsp_rd !== 5'd7) begin errors++; $display("FAIL fmul_hold got v=%0h d=%h rd=%0d want v=1 d=3f800002 rd=7", fpu_if.fpu_rsp_valid, fpu_if.fpu_rsp_wdata, fpu_if.fpu_rsp_rd); end
      checks++; if (fcsr_fflags !== 5'h00) begin errors++; $display("FAIL fmul_early_accrue got %h want 00", fcsr_fflags); end
    end
    handshake();
    csr_read(12'h001, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL fmul_fflags got %h want 00000001", d); end
  endtask

  task automatic test_illegal();
    int n;
    csr_write(12'h003, 32'h000000A0);
    checks++; if (fcsr_frm !== 3'd5 || fcsr_fflags !== 5'h00) begin errors++; $display("FAIL fcsr_write got frm=%0d ff=%h want frm=5 ff=00", fcsr_frm, fcsr_fflags); end
    alu_f_wdata = 32'h12345678; alu_f_fflags = 5'h1F;
    issue(mk(T_F7_ADD, 3'd7, 5'd4), 32'h3F800000, 32'h3F800000);
    checks++; if (fpu_if.fpu_rsp_valid !== 1'b1 || fpu_if.fpu_rsp_illegal !== 1'b1) begin errors++; $display("FAIL dyn_illegal got v=%0h ill=%0h want 1 1", fpu_if.fpu_rsp_valid, fpu_if.fpu_rsp_illegal); end
    checks++; if (fpu_if.fpu_rsp_wdata !== 32'h0) begin errors++; $display("FAIL dyn_illegal_wdata got %h want 0", fpu_if.fpu_rsp_wdata); end
    handshake();
    checks++; if (fcsr_fflags !== 5'h00) begin errors++; $display("FAIL dyn_illegal_fflags got %h want 00", fcsr_fflags); end
    alu_f_wdata = 32'h3F800000; alu_f_fflags = 5'h00;
    issue(mk(T_F7_MM, 3'b000, 5'd5), 32'h3F800000, 32'h40000000);
    checks++; if (alu_f_frm !== 3'd5) begin errors++; $display("FAIL fmin_frm_latch got %0d want 5", alu_f_frm); end
    wait_rsp(n);
    checks++; if (n != 2 || fpu_if.fpu_rsp_illegal !== 1'b0 || fpu_if.fpu_rsp_wdata !== 32'h3F800000) begin errors++; $display("FAIL fmin_legal got n=%0d ill=%0h d=%h want 2 0 3f800000", n, fpu_if.fpu_rsp_illegal, fpu_if.fpu_rsp_wdata); end
    handshake();
    issue(mk(T_F7_MM, 3'b010, 5'd5), 32'h0, 32'h0);
    checks++; if (fpu_if.fpu_rsp_valid !== 1'b1 || fpu_if.fpu_rsp_illegal !== 1'b1) begin errors++; $display("FAIL minmax_f3_illegal got v=%0h ill=%0h want 1 1", fpu_if.fpu_rsp_valid, fpu_if.fpu_rsp_illegal); end
    handshake();
    issue(mk(T_F7_DIV, 3'd0, 5'd5), 32'h0, 32'h0);
    checks++; if (fpu_if.fpu_rsp_illegal !== 1'b1) begin errors++; $display("FAIL funct7_illegal got %0h want 1", fpu_if.fpu_rsp_illegal); end
    handshake();
    issue(mk(T_F7_MUL, 3'd6, 5'd5), 32'h0, 32'h0);
    checks++; if (fpu_if.fpu_rsp_illegal !== 1'b1) begin errors++; $display("FAIL static_rm6_illegal got %0h want 1", fpu_if.fpu_rsp_illegal); end
    handshake();
    issue(mk(T_F7_ADD, 3'd4, 5'd5), 32'h0, 32'h0);
    checks++; if (fpu_if.fpu_rsp_valid !== 1'b0) begin errors++; $display("FAIL static_rmm_legal got v=%0h want 0", fpu_if.fpu_rsp_valid); end
    wait_rsp(n);
    handshake();
  endtask

  task automatic test_csr_merge();
    int n;
    logic [31:0] d;
    csr_write(12'h002, 32'h3);
    alu_f_wdata = 32'h3F800002; alu_f_fflags = 5'h01;
    issue(mk(T_F7_MUL, 3'd0, 5'd8), 32'h3F800001, 32'h3F800001);
    wait_rsp(n);
    checks++; if (n != 2) begin errors++; $display("FAIL merge_latency got %0d want 2", n); end
    fpu_if.fpu_rsp_ready = 1'b1;
    csr_we = 1'b1; csr_addr = 12'h001; csr_wdata = 32'h10;
    step();
    fpu_if.fpu_rsp_ready = 1'b0; csr_we = 1'b0;
    checks++; if (fcsr_fflags !== 5'h11) begin errors++; $display("FAIL merge_fflags got %h want 11", fcsr_fflags); end
    csr_read(12'h003, d);
    checks++; if (d !== 32'h71) begin errors++; $display("FAIL read_fcsr got %h want 00000071", d); end
    csr_read(12'h002, d);
    checks++; if (d !== 32'h3) begin errors++; $display("FAIL read_frm got %h want 00000003", d); end
    csr_read(12'h7C0, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL read_other got %h want 0", d); end
  endtask

  task automatic test_frm_same_cycle();
    int n;
    alu_f_wdata = 32'h40400000; alu_f_fflags = 5'h00;
    csr_we = 1'b1; csr_addr = 12'h002; csr_wdata = 32'h1;
    issue(mk(T_F7_ADD, 3'd7, 5'd9), 32'h3F800000, 32'h40000000);
    csr_we = 1'b0;
    checks++; if (alu_f_frm !== 3'd3 || fcsr_frm !== 3'd1) begin errors++; $display("FAIL frm_same_cycle got latched=%0d frm=%0d want 3 1", alu_f_frm, fcsr_frm); end
    wait_rsp(n);
    handshake();
    checks++; if (fcsr_fflags !== 5'h11) begin errors++; $display("FAIL frm_same_cycle_ff got %h want 11", fcsr_fflags); end
  endtask

  task automatic test_flush();
    int n;
    fpu_if.fpu_flush = 1'b1;
    #1;
    checks++; if (fpu_if.fpu_req_ready !== 1'b0) begin errors++; $display("FAIL flush_idle_ready got %0h want 0", fpu_if.fpu_req_ready); end
    fpu_if.fpu_flush = 1'b0;
    alu_f_wdata = 32'h11111111; alu_f_fflags = 5'h04;
    issue(mk(T_F7_ADD, 3'd0, 5'd10), 32'h0, 32'h0);
    fpu_if.fpu_flush = 1'b1;
    step();
    fpu_if.fpu_flush = 1'b0;
    #1;
    checks++; if (fpu_if.fpu_req_ready !== 1'b1 || fpu_if.fpu_rsp_valid !== 1'b0) begin errors++; $display("FAIL flush_exec got r=%0h v=%0h want r=1 v=0", fpu_if.fpu_req_ready, fpu_if.fpu_rsp_valid); end
    step(); step(); step();
    checks++; if (fpu_if.fpu_rsp_valid !== 1'b0 || fcsr_fflags !== 5'h11) begin errors++; $display("FAIL flush_exec_after got v=%0h ff=%h want 0 11", fpu_if.fpu_rsp_valid, fcsr_fflags); end
    issue(mk(T_F7_ADD, 3'd0, 5'd10), 32'h0, 32'h0);
    wait_rsp(n);
    checks++; if (n != 2) begin errors++; $display("FAIL flush_resp_latency got %0d want 2", n); end
    fpu_if.fpu_rsp_ready = 1'b1; fpu_if.fpu_flush = 1'b1;
    step();
    fpu_if.fpu_rsp_ready = 1'b0; fpu_if.fpu_flush = 1'b0;
    checks++; if (fcsr_fflags !== 5'h11 || fpu_if.fpu_rsp_valid !== 1'b0) begin errors++; $display("FAIL flush_resp got ff=%h v=%0h want 11 0", fcsr_fflags, fpu_if.fpu_rsp_valid); end
  endtask

  task automatic test_async_reset();
    int n;
    logic [31:0] d;
    alu_f_wdata = 32'h40000000; alu_f_fflags = 5'h00;
    issue(mk(T_F7_ADD, 3'd0, 5'd11), 32'h3F800000, 32'h3F800000);
    #3 rst = 1'b1;
    #1;
    checks++; if (alu_f_insn !== 32'h0 || alu_f_rdata1 !== 32'h0 || fpu_if.fpu_rsp_valid !== 1'b0) begin errors++; $display("FAIL async_rst_outs got insn=%h a=%h v=%0h want 0", alu_f_insn, alu_f_rdata1, fpu_if.fpu_rsp_valid); end
    checks++; if (fcsr_frm !== 3'd0 || fcsr_fflags !== 5'h00) begin errors++; $display("FAIL async_rst_fcsr got frm=%0d ff=%h want 0 00", fcsr_frm, fcsr_fflags); end
    csr_read(12'h003, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL async_rst_rdata got %h want 0", d); end
    #1 rst = 1'b0;
    step();
    checks++; if (fpu_if.fpu_req_ready !== 1'b1 || fpu_if.fpu_rsp_valid !== 1'b0) begin errors++; $display("FAIL async_rst_idle got r=%0h v=%0h want 1 0", fpu_if.fpu_req_ready, fpu_if.fpu_rsp_valid); end
    issue(mk(T_F7_ADD, 3'd0, 5'd12), 32'h3F800000, 32'h3F800000);
    wait_rsp(n);
    checks++; if (n != 2 || fpu_if.fpu_rsp_wdata !== 32'h40000000 || fpu_if.fpu_rsp_rd !== 5'd12) begin errors++; $display("FAIL post_rst_op got n=%0d d=%h rd=%0d want 2 40000000 12", n, fpu_if.fpu_rsp_wdata, fpu_if.fpu_rsp_rd); end
    handshake();
  endtask

  initial begin
    fpu_if.fpu_req_valid  = 1'b0;
    fpu_if.fpu_req_insn   = '0;
    fpu_if.fpu_req_rdata1 = '0;
    fpu_if.fpu_req_rdata2 = '0;
    fpu_if.fpu_flush      = 1'b0;
    fpu_if.fpu_rsp_ready  = 1'b0;
    #12 rst = 1'b0;
    step();
    test_reset();
    test_fadd();
    test_fmul_hold();
    test_illegal();
    test_csr_merge();
    test_frm_same_cycle();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
